// File: rtl/haar_rect_sum_if.sv
// Request, integral-image read and result signals of haar_rect_sum.
// The rect_weight signal exists only when RECT_WEIGHT_EN is defined.
interface haar_rect_sum_if #(
  parameter int DATA_W = 20,
`ifdef RECT_WEIGHT_EN
  parameter int SUM_W  = DATA_W + 5
`else
  parameter int SUM_W  = DATA_W + 2
`endif
);
  logic                     req_valid;
  logic                     req_ready;
  logic [7:0]               rect_x;
  logic [6:0]               rect_y;
  logic [7:0]               rect_w;
  logic [6:0]               rect_h;
`ifdef RECT_WEIGHT_EN
  logic signed [2:0]        rect_weight;
`endif
  logic                     rd_en;
  logic [14:0]              rd_addr;
  logic [DATA_W-1:0]        data_in;
  logic                     sum_valid;
  logic signed [SUM_W-1:0]  sum;
  logic                     rect_err;

  modport master (
`ifdef RECT_WEIGHT_EN
    output rect_weight,
`endif
    output req_valid, rect_x, rect_y, rect_w, rect_h, data_in,
    input  req_ready, rd_en, rd_addr, sum_valid, sum, rect_err
  );

  modport slave (
`ifdef RECT_WEIGHT_EN
    input  rect_weight,
`endif
    input  req_valid, rect_x, rect_y, rect_w, rect_h, data_in,
    output req_ready, rd_en, rd_addr, sum_valid, sum, rect_err
  );
endinterface

// File: rtl/haar_rect_sum.sv
// Rectangle-sum fetch engine: reads up to four integral-image corners and returns D - B - C + A.
// Define RECT_WEIGHT_EN to scale the result by a signed 3-bit rect_weight latched on accept.
module haar_rect_sum #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int DATA_W     = 20,
  parameter int RD_LATENCY = 2,
`ifdef RECT_WEIGHT_EN
  parameter int SUM_W      = DATA_W + 5
`else
  parameter int SUM_W      = DATA_W + 2
`endif
) (
  input  logic           clk,
  input  logic           rst,
  haar_rect_sum_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StErr} state_e;

  state_e                  r_state, w_state_nxt;
  logic [7:0]              r_x, r_w;
  logic [6:0]              r_y, r_h;
  logic [1:0]              r_slot;
  logic [2:0]              r_drain;
  logic [RD_LATENCY-1:0]   r_tag_used, r_tag_neg;
  logic signed [SUM_W-1:0] r_acc, r_sum;

  logic                    w_accept, w_bad, w_issue, w_used, w_neg, w_rd;
  logic [7:0]              w_col_lo, w_col_hi, w_col;
  logic [6:0]              w_row_lo, w_row_hi, w_row;
  logic [14:0]             w_addr;
  logic signed [SUM_W-1:0] w_data_ext, w_final;

`ifdef RECT_WEIGHT_EN
  logic signed [2:0]       r_weight;
  logic signed [SUM_W-1:0] w_weight_ext;
  assign w_weight_ext = {{(SUM_W-3){r_weight[2]}}, r_weight};
  assign w_final      = r_acc * w_weight_ext;
`else
  assign w_final      = r_acc;
`endif

  assign w_accept = (r_state == StIdle) && bus.req_valid;
  assign w_bad    = (bus.rect_w == 8'd0) || (bus.rect_h == 7'd0) ||
                    (({1'b0, bus.rect_x} + {1'b0, bus.rect_w}) > 9'(IMG_W)) ||
                    (({1'b0, bus.rect_y} + {1'b0, bus.rect_h}) > 8'(IMG_H));

  assign w_col_lo = r_x - 8'd1;
  assign w_col_hi = r_x + r_w - 8'd1;
  assign w_row_lo = r_y - 7'd1;
  assign w_row_hi = r_y + r_h - 7'd1;

  // Slot order A, B, C, D; corners on the x=0 column or y=0 row are skipped.
  always_comb begin
    w_used = 1'b0;
    w_neg  = 1'b0;
    w_col  = w_col_hi;
    w_row  = w_row_hi;
    unique case (r_slot)
      2'd0: begin w_used = (r_x != 8'd0) && (r_y != 7'd0); w_col = w_col_lo; w_row = w_row_lo; end
      2'd1: begin w_used = (r_y != 7'd0); w_neg = 1'b1; w_row = w_row_lo; end
      2'd2: begin w_used = (r_x != 8'd0); w_neg = 1'b1; w_col = w_col_lo; end
      default: w_used = 1'b1;
    endcase
  end

  assign w_issue     = (r_state == StIssue);
  assign w_rd        = w_issue && w_used && !rst;
  assign w_addr      = 15'(w_row) * 15'(IMG_W) + 15'(w_col);
  assign bus.rd_en   = w_rd;
  assign bus.rd_addr = w_rd ? w_addr : 15'd0;
  assign w_data_ext  = {{(SUM_W-DATA_W){1'b0}}, bus.data_in};

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    bus.sum_valid = 1'b0;
    bus.rect_err  = 1'b0;
    bus.sum       = r_sum;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = w_bad ? StErr : StIssue;
      end
      StIssue: if (r_slot == 2'd3) w_state_nxt = StDrain;
      StDrain: if (r_drain == 3'(RD_LATENCY - 1)) w_state_nxt = StDone;
      StDone: begin
        bus.sum_valid = 1'b1;
        bus.sum       = w_final;
        w_state_nxt   = StIdle;
      end
      StErr: begin
        bus.sum_valid = 1'b1;
        bus.rect_err  = 1'b1;
        bus.sum       = '0;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (rst) begin
      bus.req_ready = 1'b0;
      bus.sum_valid = 1'b0;
      bus.rect_err  = 1'b0;
      bus.sum       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0;
      r_slot     <= '0;
      r_drain    <= '0;
      r_tag_used <= '0;
      r_tag_neg  <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
`ifdef RECT_WEIGHT_EN
      r_weight   <= '0;
`endif
    end else begin
      // Tag pipe lines each slot's {used, sign} up with its returning data word.
      r_tag_used[0] <= w_issue && w_used;
      r_tag_neg[0]  <= w_neg;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_used[i] <= r_tag_used[i-1];
        r_tag_neg[i]  <= r_tag_neg[i-1];
      end
      if (r_tag_used[RD_LATENCY-1]) begin
        r_acc <= r_tag_neg[RD_LATENCY-1] ? (r_acc - w_data_ext) : (r_acc + w_data_ext);
      end
      if (w_issue) begin
        r_slot  <= r_slot + 2'd1;
        r_drain <= '0;
      end
      if (r_state == StDrain) r_drain <= r_drain + 3'd1;
      if (r_state == StDone)  r_sum   <= w_final;
      if (r_state == StErr)   r_sum   <= '0;
      if (w_accept) begin
        r_x    <= bus.rect_x;
        r_y    <= bus.rect_y;
        r_w    <= bus.rect_w;
        r_h    <= bus.rect_h;
        r_slot <= '0;
        r_acc  <= '0;
`ifdef RECT_WEIGHT_EN
        r_weight <= bus.rect_weight;
`endif
      end
    end
  end

endmodule

// File: tb/tb_haar_rect_sum.sv
// Bench for haar_rect_sum over an all-ones image, II(c,r) = (c+1)*(r+1).
// Define RECT_WEIGHT_EN to exercise the weighted build.
module tb_haar_rect_sum;
  localparam int IMG_W      = 160;
  localparam int IMG_H      = 120;
  localparam int DATA_W     = 20;
  localparam int RD_LATENCY = 2;
`ifdef RECT_WEIGHT_EN
  localparam int SUM_W      = DATA_W + 5;
`else
  localparam int SUM_W      = DATA_W + 2;
`endif
  localparam int SUM_OFF    = 5 + RD_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  haar_rect_sum_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  haar_rect_sum #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .SUM_W(SUM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // BRAM model: data for an address appears RD_LATENCY cycles after it is presented.
  logic [14:0] p_addr [RD_LATENCY];
  always @(posedge clk) begin
    p_addr[0] <= bus.rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) p_addr[i] <= p_addr[i-1];
  end

  function automatic int ii_val(input int a);
    return (a % IMG_W + 1) * (a / IMG_W + 1);
  endfunction

  assign bus.data_in = DATA_W'(ii_val(int'(p_addr[RD_LATENCY-1])));

  int n_checks = 0;
  int n_fail   = 0;

  int rd_addr_q[$];
  int rd_off_q[$];
  int sv_n, sv_off, sv_sum;
  bit sv_err;
  int exp_addr_q[$];
  int exp_off_q[$];

  function automatic bit model_err(input int x, y, w, h);
    return (w == 0) || (h == 0) || (x + w > IMG_W) || (y + h > IMG_H);
  endfunction

  function automatic void model_reads(input int x, y, w, h);
    exp_addr_q.delete();
    exp_off_q.delete();
    if (x > 0 && y > 0) begin exp_addr_q.push_back((y-1)*IMG_W + x-1);     exp_off_q.push_back(1); end
    if (y > 0)          begin exp_addr_q.push_back((y-1)*IMG_W + x+w-1);   exp_off_q.push_back(2); end
    if (x > 0)          begin exp_addr_q.push_back((y+h-1)*IMG_W + x-1);   exp_off_q.push_back(3); end
    exp_addr_q.push_back((y+h-1)*IMG_W + x+w-1);
    exp_off_q.push_back(4);
  endfunction

  // Drives one request and logs reads and sum_valid over a fixed window (offsets from accept).
  task automatic run_req(input int x, y, w, h, wt, input bit hold2, output bit ready_low2);
    int guard = 0;
    rd_addr_q.delete();
    rd_off_q.delete();
    sv_n = 0; sv_off = -1; sv_sum = 0; sv_err = 1'b0; ready_low2 = 1'b0;
    @(negedge clk);
    while (!bus.req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, guard);
    end
    bus.rect_x = 8'(x);
    bus.rect_y = 7'(y);
    bus.rect_w = 8'(w);
    bus.rect_h = 7'(h);
`ifdef RECT_WEIGHT_EN
    bus.rect_weight = 3'(wt);
`endif
    bus.req_valid = 1'b1;
    for (int off = 1; off <= 14; off++) begin
      @(negedge clk);
      if (off == 1) begin
        bus.req_valid = hold2;
        ready_low2    = !bus.req_ready;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.rd_en) begin
        rd_addr_q.push_back(int'(bus.rd_addr));
        rd_off_q.push_back(off);
      end
      if (bus.sum_valid) begin
        sv_n++;
        if (sv_off < 0) begin
          sv_off = off;
          sv_sum = int'($signed(bus.sum));
          sv_err = bus.rect_err;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_in_rst: got %0b, required 0", bus.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.rd_en, bus.sum_valid, bus.rect_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/rd_en/valid/err got %b, required 1000",
               {bus.req_ready, bus.rd_en, bus.sum_valid, bus.rect_err});
    end
    n_checks++;
    if (bus.rd_addr !== 15'd0 || bus.sum !== '0) begin
      n_fail++; $display("FAIL reset_data: rd_addr=%0d sum=%0d, required 0 0", bus.rd_addr, bus.sum);
    end
  endtask

  task automatic test_basic();
    bit rl;
    run_req(10, 20, 4, 5, 1, 1'b0, rl);
    model_reads(10, 20, 4, 5);
    n_checks++;
    if (sv_n != 1 || sv_off != SUM_OFF || sv_sum != 20 || sv_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: n=%0d off=%0d sum=%0d err=%0b, required 1 %0d 20 0",
               sv_n, sv_off, sv_sum, sv_err, SUM_OFF);
    end
    n_checks++;
    if (rd_addr_q != exp_addr_q || rd_off_q != exp_off_q) begin
      n_fail++;
      $display("FAIL basic_reads: addr=%p off=%p, required %p %p",
               rd_addr_q, rd_off_q, exp_addr_q, exp_off_q);
    end
    n_checks++;
    if (int'($signed(bus.sum)) != 20) begin
      n_fail++; $display("FAIL basic_hold: sum=%0d after strobe, required 20", $signed(bus.sum));
    end
  endtask

  task automatic test_full_frame();
    bit rl;
    run_req(0, 0, 160, 120, 1, 1'b0, rl);
    n_checks++;
    if (sv_n != 1 || sv_off != SUM_OFF || sv_sum != 19200 || sv_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame_sum: n=%0d off=%0d sum=%0d err=%0b, required 1 %0d 19200 0",
               sv_n, sv_off, sv_sum, sv_err, SUM_OFF);
    end
    n_checks++;
    if (rd_addr_q.size() != 1 || rd_addr_q[0] != 19199 || rd_off_q[0] != 4) begin
      n_fail++;
      $display("FAIL full_frame_reads: addr=%p off=%p, required '{19199} '{4}", rd_addr_q, rd_off_q);
    end
  endtask

  task automatic test_err();
    bit rl;
    int tx[3] = '{157, 5, 0};
    int ty[3] = '{0, 5, 118};
    int tw[3] = '{4, 0, 1};
    int th[3] = '{1, 3, 3};
    for (int k = 0; k < 3; k++) begin
      run_req(tx[k], ty[k], tw[k], th[k], 1, 1'b0, rl);
      n_checks++;
      if (sv_n != 1 || sv_off != 1 || sv_sum != 0 || sv_err !== 1'b1 || rd_addr_q.size() != 0) begin
        n_fail++;
        $display("FAIL err_case%0d: n=%0d off=%0d sum=%0d err=%0b reads=%0d, required 1 1 0 1 0",
                 k, sv_n, sv_off, sv_sum, sv_err, rd_addr_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit rl;
    run_req(10, 20, 4, 5, 1, 1'b1, rl);
    n_checks++;
    if (rl !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: req_ready low after accept got %0b, required 1", rl);
    end
    n_checks++;
    if (sv_n != 1 || sv_sum != 20 || rd_addr_q.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_single: n=%0d sum=%0d reads=%0d, required 1 20 4",
               sv_n, sv_sum, rd_addr_q.size());
    end
    run_req(3, 4, 5, 6, 1, 1'b0, rl);
    n_checks++;
    if (sv_n != 1 || sv_off != SUM_OFF || sv_sum != 30 || sv_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reissue: n=%0d off=%0d sum=%0d err=%0b, required 1 %0d 30 0",
               sv_n, sv_off, sv_sum, sv_err, SUM_OFF);
    end
  endtask

  task automatic test_reset_mid();
    bit rl;
    int guard = 0;
    int nv = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 40) begin @(negedge clk); guard++; end
    bus.rect_x = 8'd10; bus.rect_y = 7'd20; bus.rect_w = 8'd4; bus.rect_h = 7'd5;
`ifdef RECT_WEIGHT_EN
    bus.rect_weight = 3'sd1;
`endif
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ready_in_rst: got %0b, required 0", bus.req_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
          n_fail++; $display("FAIL midrst_ready_after: got %0b, required 1", bus.req_ready);
        end
      end
      if (bus.sum_valid) nv++;
    end
    n_checks++;
    if (nv != 0) begin
      n_fail++; $display("FAIL midrst_no_valid: %0d sum_valid pulses, required 0", nv);
    end
    run_req(10, 20, 4, 5, 1, 1'b0, rl);
    n_checks++;
    if (sv_n != 1 || sv_off != SUM_OFF || sv_sum != 20 || sv_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_next: n=%0d off=%0d sum=%0d err=%0b, required 1 %0d 20 0",
               sv_n, sv_off, sv_sum, sv_err, SUM_OFF);
    end
  endtask

  task automatic test_random();
    bit rl;
    int x, y, w, h, wt, exp_sum, exp_off;
    bit exp_err;
    for (int it = 0; it < 24; it++) begin
      x = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 170);
      y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 127);
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
`ifdef RECT_WEIGHT_EN
      wt = int'($urandom_range(0, 7)) - 4;
`else
      wt = 1;
`endif
      exp_err = model_err(x, y, w, h);
      exp_sum = exp_err ? 0 : w * h * wt;
      exp_off = exp_err ? 1 : SUM_OFF;
      run_req(x, y, w, h, wt, 1'b0, rl);
      n_checks++;
      if (sv_n != 1 || sv_off != exp_off || sv_sum != exp_sum || sv_err !== exp_err) begin
        n_fail++;
        $display("FAIL rand%0d (%0d,%0d,%0d,%0d,w%0d): n=%0d off=%0d sum=%0d err=%0b, required 1 %0d %0d %0b",
                 it, x, y, w, h, wt, sv_n, sv_off, sv_sum, sv_err, exp_off, exp_sum, exp_err);
      end
      if (exp_err) begin
        exp_addr_q.delete();
        exp_off_q.delete();
      end else begin
        model_reads(x, y, w, h);
      end
      n_checks++;
      if (rd_addr_q != exp_addr_q || rd_off_q != exp_off_q) begin
        n_fail++;
        $display("FAIL rand%0d_reads: addr=%p off=%p, required %p %p",
                 it, rd_addr_q, rd_off_q, exp_addr_q, exp_off_q);
      end
    end
  endtask

`ifdef RECT_WEIGHT_EN
  task automatic test_weight();
    bit rl;
    run_req(10, 20, 4, 5, -2, 1'b0, rl);
    n_checks++;
    if (sv_n != 1 || sv_off != SUM_OFF || sv_sum != -40) begin
      n_fail++;
      $display("FAIL weight_neg2: n=%0d off=%0d sum=%0d, required 1 %0d -40", sv_n, sv_off, sv_sum, SUM_OFF);
    end
    run_req(10, 20, 4, 5, 0, 1'b0, rl);
    n_checks++;
    if (sv_n != 1 || sv_sum != 0 || rd_addr_q.size() != 4) begin
      n_fail++;
      $display("FAIL weight_zero: n=%0d sum=%0d reads=%0d, required 1 0 4",
               sv_n, sv_sum, rd_addr_q.size());
    end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0;
`ifdef RECT_WEIGHT_EN
    bus.rect_weight = '0;
`endif
    test_reset();
    test_basic();
    test_full_frame();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef RECT_WEIGHT_EN
    test_weight();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
